// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - instruction fetch initiator with PC, prefetch queue, redirect and halt
// Optional FETCH_STATS_EN adds saturating fetch_count/stall_count outputs.
module imem_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = 32'h0000_0020,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic pop, can_push, fetch_try, push;

  assign pop       = (count_q != '0) && out_ready;
  assign can_push  = (count_q != DEPTH_C) || pop;
  assign fetch_try = (state_q == FETCH) && fetch_en && (pc_q != PC_LIMIT) && !redirect_valid;
  assign push      = fetch_try && can_push;

  assign imem_addr = {pc_q[31:2], 2'b00};
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem[head_q] : 32'h0;
  assign out_pc    = out_valid ? pc_mem[head_q]    : 32'h0;
  assign halted    = (state_q == HALT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = fetch_en ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (fetch_en) state_d = FETCH;
        FETCH: begin
          if (!fetch_en)              state_d = IDLE;
          else if (pc_q == PC_LIMIT)  state_d = HALT;
          else if (push)              pc_d    = pc_q + 32'd4;
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (redirect_valid) begin
        // A same-cycle pop is consumed by decode; the flush discards the rest.
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + 1'b1;
        if (pop)  head_q <= head_q + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Payload storage needs no reset: out_* are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= imem_addr;
      instr_mem[tail_q] <= imem_instr;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, stall_count_q;
  logic        stall;

  assign stall       = fetch_try && !can_push;
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else if (redirect_valid) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (push && (fetch_count_q != 32'hFFFF_FFFF))  fetch_count_q <= fetch_count_q + 32'd1;
      if (stall && (stall_count_q != 32'hFFFF_FFFF)) stall_count_q <= stall_count_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb/tb_imem_fetch_unit.sv - directed self-checking bench for imem_fetch_unit
module tb_imem_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk, rst_n;
  logic        fetch_en, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid, halted;

  logic        fetch_en2;
  logic [31:0] imem_addr2, imem_instr2, out_instr2, out_pc2;
  logic        out_valid2, halted2;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

  int errors = 0;
  int checks = 0;

  assign imem_instr  = imem_addr  ^ KEY;
  assign imem_instr2 = imem_addr2 ^ KEY;

  imem_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
`ifdef FETCH_STATS_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .halted(halted)
  );

  imem_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .PC_LIMIT(32'h0000_0008), .DEPTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en2),
    .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid2), .out_ready(1'b1),
    .out_instr(out_instr2), .out_pc(out_pc2),
`ifdef FETCH_STATS_EN
    .fetch_count(fetch_count2), .stall_count(stall_count2),
`endif
    .halted(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          n;

    rst_n = 1'b0; fetch_en = 1'b0; fetch_en2 = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_addr2", imem_addr2, 32'hFFFF_FFF8);
`ifdef FETCH_STATS_EN
    check("rst_fetch_cnt", fetch_count, 32'h0);
    check("rst_stall_cnt", stall_count, 32'h0);
`endif

    // Streaming run to PC_LIMIT
    rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    exp_pc = 32'h0; n = 0;
    for (int i = 0; i < 30 && n < 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        check("t1_pc", out_pc, exp_pc);
        check("t1_instr", out_instr, exp_pc ^ KEY);
        exp_pc += 32'd4; n++;
      end
    end
    check("t1_count", n, 8);
    @(negedge clk);
    check("t1_halted", {31'h0, halted}, 32'h1);
    check("t1_empty", {31'h0, out_valid}, 32'h0);
    check("t1_addr", imem_addr, 32'h20);

    // Redirect out of HALT
    redirect_valid = 1'b1; redirect_pc = 32'h4;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t4_halted", {31'h0, halted}, 32'h0);
    check("t4_empty", {31'h0, out_valid}, 32'h0);
    check("t4_addr", imem_addr, 32'h4);
    @(negedge clk);
    check("t4_pc0", out_pc, 32'h4);
    @(negedge clk);
    check("t4_pc1", out_pc, 32'h8);

    // Full queue stall, then push+pop at full
    redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("t2_addr_hold", imem_addr, 32'h10);
    check("t2_head", out_pc, 32'h0);
`ifdef FETCH_STATS_EN
    check("t2_stall_cnt", stall_count, 32'd2);
    check("t2_fetch_cnt", fetch_count, 32'd4);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t2_pp_head", out_pc, 32'h4);
    check("t2_pp_addr", imem_addr, 32'h14);
`ifdef FETCH_STATS_EN
    check("t2_pp_fetch_cnt", fetch_count, 32'd5);
`endif
    @(negedge clk);
    check("t2_hold_head", out_pc, 32'h4);
    check("t2_hold_instr", out_instr, 32'h4 ^ KEY);
    fetch_en = 1'b0; out_ready = 1'b1;
    @(negedge clk); check("t2_drain0", out_pc, 32'h8);
    @(negedge clk); check("t2_drain1", out_pc, 32'hC);
    @(negedge clk); check("t2_drain2", out_pc, 32'h10);
    @(negedge clk);
    check("t2_drained", {31'h0, out_valid}, 32'h0);
    check("t2_pc_kept", imem_addr, 32'h14);

    // Redirect with 3 queued entries and a same-cycle pop
    fetch_en = 1'b1; out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_head", out_pc, 32'h0);
    check("t3_addr", imem_addr, 32'hC);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0009;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t3_flushed", {31'h0, out_valid}, 32'h0);
    check("t3_addr_redir", imem_addr, 32'h8);
    @(negedge clk);
    check("t3_pc0", out_pc, 32'h8);
    check("t3_instr0", out_instr, 32'h8 ^ KEY);
    @(negedge clk);
    check("t3_pc1", out_pc, 32'hC);

    // Asynchronous reset pulse mid-stream
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_valid", {31'h0, out_valid}, 32'h0);
    check("t5_addr", imem_addr, 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t5_lat_empty", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    check("t5_lat_valid", {31'h0, out_valid}, 32'h1);
    check("t5_pc0", out_pc, 32'h0);

    // Wrapping PC on the second instance
    fetch_en2 = 1'b1;
    exp_pc = 32'hFFFF_FFF8; n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (out_valid2) begin
        check("t6_pc", out_pc2, exp_pc);
        check("t6_instr", out_instr2, exp_pc ^ KEY);
        exp_pc += 32'd4; n++;
      end
    end
    check("t6_count", n, 4);
    @(negedge clk);
    check("t6_halted", {31'h0, halted2}, 32'h1);
    check("t6_empty", {31'h0, out_valid2}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
